// File: rtl/stack_alu.sv
// rtl/stack_alu.sv - registered 16-bit stack ALU, one result per clock
// Define ALU_OVERFLOW_EN to compute and register the carry/borrow flag; otherwise Overflow is 0.
module stack_alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       Oper,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] ALU_Out,
  output logic             Overflow
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_AND  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_SELA = 4'b0101,
    OP_SELB = 4'b0110,
    OP_EQ   = 4'b0111,
    OP_ZERO = 4'b1000,
    OP_LT   = 4'b1001
  } op_t;

  localparam logic [WIDTH-2:0] HI_ZERO = '0;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] result;

`ifdef ALU_OVERFLOW_EN
  logic [WIDTH:0] sum_w;
  logic [WIDTH:0] diff_w;
  logic           flag;

  // The extra top bit of the widened add/subtract is the carry or borrow.
  assign sum_w  = {1'b0, A} + {1'b0, B};
  assign diff_w = {1'b0, A} - {1'b0, B};
  assign sum    = sum_w[WIDTH-1:0];
  assign diff   = diff_w[WIDTH-1:0];

  always_comb begin
    flag = 1'b0;
    case (Oper)
      OP_ADD:  flag = sum_w[WIDTH];
      OP_SUB:  flag = diff_w[WIDTH];
      default: flag = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Overflow <= 1'b0;
    end else begin
      Overflow <= flag;
    end
  end
`else
  assign sum      = A + B;
  assign diff     = A - B;
  assign Overflow = 1'b0;
`endif

  always_comb begin
    result = '0;
    case (Oper)
      OP_ADD:  result = sum;
      OP_SUB:  result = diff;
      OP_AND:  result = A & B;
      OP_OR:   result = A | B;
      OP_XOR:  result = A ^ B;
      OP_SELA: result = A;
      OP_SELB: result = B;
      OP_EQ:   result = {HI_ZERO, (A == B)};
      OP_ZERO: result = {HI_ZERO, (A == '0)};
      OP_LT:   result = {HI_ZERO, (B < A)};
      default: result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ALU_Out <= '0;
    end else begin
      ALU_Out <= result;
    end
  end

endmodule

// File: tb/tb_stack_alu.sv
// tb/tb_stack_alu.sv - scoreboard bench for stack_alu
// Overflow expectations follow ALU_OVERFLOW_EN.
module tb_stack_alu;

`ifdef ALU_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  Oper;
  logic [15:0] A;
  logic [15:0] B;
  logic [15:0] ALU_Out;
  logic        Overflow;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        ovf;
  } item_t;

  item_t stim[$];
  item_t sb[$];

  stack_alu #(.WIDTH(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .Oper(Oper),
    .A(A),
    .B(B),
    .ALU_Out(ALU_Out),
    .Overflow(Overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout ALU_Out=%h Overflow=%b required=finish", ALU_Out, Overflow);
    $fatal(1, "timeout");
  end

  task automatic add_stim(input string name, input logic [3:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] res, input logic ovf);
    item_t it;
    it.name = name; it.op = op; it.a = a; it.b = b; it.res = res; it.ovf = ovf & OVF_EN;
    stim.push_back(it);
  endtask

  task automatic test_reset();
    item_t e;
    rst_n = 1'b0; Oper = 4'b0000; A = 16'hFFFF; B = 16'hFFFF;
    for (int i = 0; i < 2; i++) begin
      e.name = "reset"; e.res = 16'h0000; e.ovf = 1'b0;
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (ALU_Out !== e.res || Overflow !== e.ovf) begin
        failures++;
        $display("FAIL %s: ALU_Out=%h Overflow=%b required %h/%b", e.name, ALU_Out, Overflow, e.res, e.ovf);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    item_t s, e;
    add_stim("add_6_9",     4'b0000, 16'h0006, 16'h0009, 16'h000F, 1'b0);
    add_stim("add_ffff_1",  4'b0000, 16'hFFFF, 16'h0001, 16'h0000, 1'b1);
    add_stim("add_fffe_1",  4'b0000, 16'hFFFE, 16'h0001, 16'hFFFF, 1'b0);
    while (stim.size() > 0) begin
      s = stim.pop_front();
      Oper = s.op; A = s.a; B = s.b;
      sb.push_back(s);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (ALU_Out !== e.res || Overflow !== e.ovf) begin
        failures++;
        $display("FAIL %s: ALU_Out=%h Overflow=%b required %h/%b", e.name, ALU_Out, Overflow, e.res, e.ovf);
      end
    end
  endtask

  task automatic test_sub_logic();
    item_t s, e;
    add_stim("sub_dead_beef", 4'b0001, 16'hDEAD, 16'hBEEF, 16'h1FBE, 1'b0);
    add_stim("sub_0_1",       4'b0001, 16'h0000, 16'h0001, 16'hFFFF, 1'b1);
    add_stim("sub_1111_1111", 4'b0001, 16'h1111, 16'h1111, 16'h0000, 1'b0);
    add_stim("and",           4'b0010, 16'hAAAA, 16'hBBBB, 16'hAAAA, 1'b0);
    add_stim("or",            4'b0011, 16'h2345, 16'hABCD, 16'hABCD, 1'b0);
    add_stim("xor",           4'b0100, 16'h0000, 16'hFFFF, 16'hFFFF, 1'b0);
    add_stim("sel_a",         4'b0101, 16'h1234, 16'h5678, 16'h1234, 1'b0);
    add_stim("sel_b",         4'b0110, 16'h4321, 16'hFFFF, 16'hFFFF, 1'b0);
    while (stim.size() > 0) begin
      s = stim.pop_front();
      Oper = s.op; A = s.a; B = s.b;
      sb.push_back(s);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (ALU_Out !== e.res || Overflow !== e.ovf) begin
        failures++;
        $display("FAIL %s: ALU_Out=%h Overflow=%b required %h/%b", e.name, ALU_Out, Overflow, e.res, e.ovf);
      end
    end
  endtask

  task automatic test_compare();
    item_t s, e;
    add_stim("eq_diff",   4'b0111, 16'hAAAA, 16'hBBBB, 16'h0000, 1'b0);
    add_stim("eq_same",   4'b0111, 16'h0ABC, 16'h0ABC, 16'h0001, 1'b0);
    add_stim("eq_20_10",  4'b0111, 16'h0020, 16'h0010, 16'h0000, 1'b0);
    add_stim("zero_ca11", 4'b1000, 16'hCA11, 16'h0000, 16'h0000, 1'b0);
    add_stim("zero_0",    4'b1000, 16'h0000, 16'hFFFF, 16'h0001, 1'b0);
    add_stim("lt_aaaa",   4'b1001, 16'hAAAA, 16'hBBBB, 16'h0000, 1'b0);
    add_stim("lt_deed",   4'b1001, 16'hDEED, 16'hCADE, 16'h0001, 1'b0);
    add_stim("lt_deaf",   4'b1001, 16'hDEAF, 16'hDEAD, 16'h0001, 1'b0);
    add_stim("lt_equal",  4'b1001, 16'h5555, 16'h5555, 16'h0000, 1'b0);
    add_stim("rsvd_1111", 4'b1111, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0);
    add_stim("rsvd_1010", 4'b1010, 16'hFFFF, 16'h0001, 16'h0000, 1'b0);
    while (stim.size() > 0) begin
      s = stim.pop_front();
      Oper = s.op; A = s.a; B = s.b;
      sb.push_back(s);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (ALU_Out !== e.res || Overflow !== e.ovf) begin
        failures++;
        $display("FAIL %s: ALU_Out=%h Overflow=%b required %h/%b", e.name, ALU_Out, Overflow, e.res, e.ovf);
      end
    end
  endtask

  task automatic test_back_to_back();
    item_t s, e;
    logic [16:0] wide;
    for (int i = 0; i < 16; i++) begin
      s.a = 16'($urandom());
      s.b = (i == 4) ? (16'hFFFF - s.a + 16'd1) : 16'($urandom());
      if (i % 2 == 0) begin
        wide = {1'b0, s.a} + {1'b0, s.b};
        add_stim("b2b_add", 4'b0000, s.a, s.b, wide[15:0], wide[16]);
      end else begin
        add_stim("b2b_xor", 4'b0100, s.a, s.b, s.a ^ s.b, 1'b0);
      end
    end
    while (stim.size() > 0) begin
      s = stim.pop_front();
      Oper = s.op; A = s.a; B = s.b;
      sb.push_back(s);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (ALU_Out !== e.res || Overflow !== e.ovf) begin
        failures++;
        $display("FAIL %s: ALU_Out=%h Overflow=%b required %h/%b", e.name, ALU_Out, Overflow, e.res, e.ovf);
      end
    end
  endtask

  task automatic test_hold_and_midreset();
    item_t e;
    Oper = 4'b0000; A = 16'h0001; B = 16'h0002;
    e.name = "hold_first"; e.res = 16'h0003; e.ovf = 1'b0;
    sb.push_back(e);
    @(posedge clk); #1;
    // Inputs change between edges; registered outputs must not follow.
    Oper = 4'b0100; A = 16'hF0F0; B = 16'h0FF0;
    #2;
    e = sb.pop_front();
    checks++;
    if (ALU_Out !== e.res || Overflow !== e.ovf) begin
      failures++;
      $display("FAIL %s: ALU_Out=%h Overflow=%b required %h/%b", e.name, ALU_Out, Overflow, e.res, e.ovf);
    end
    e.name = "hold_next"; e.res = 16'hFF00; e.ovf = 1'b0;
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if (ALU_Out !== e.res || Overflow !== e.ovf) begin
      failures++;
      $display("FAIL %s: ALU_Out=%h Overflow=%b required %h/%b", e.name, ALU_Out, Overflow, e.res, e.ovf);
    end
    Oper = 4'b0000; A = 16'hFFFF; B = 16'h0003; rst_n = 1'b0;
    e.name = "midreset"; e.res = 16'h0000; e.ovf = 1'b0;
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if (ALU_Out !== e.res || Overflow !== e.ovf) begin
      failures++;
      $display("FAIL %s: ALU_Out=%h Overflow=%b required %h/%b", e.name, ALU_Out, Overflow, e.res, e.ovf);
    end
    rst_n = 1'b1;
    e.name = "after_reset"; e.res = 16'h0002; e.ovf = OVF_EN;
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if (ALU_Out !== e.res || Overflow !== e.ovf) begin
      failures++;
      $display("FAIL %s: ALU_Out=%h Overflow=%b required %h/%b", e.name, ALU_Out, Overflow, e.res, e.ovf);
    end
  endtask

  initial begin
    rst_n = 1'b0; Oper = 4'b0000; A = 16'h0000; B = 16'h0000;
    @(negedge clk);
    test_reset();
    test_add();
    test_sub_logic();
    test_compare();
    test_back_to_back();
    test_hold_and_midreset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
